clk_pulse_scheduler: RTL and testbench

//   Synthesizable controller that sequences a programmable clock/pulse waveform.

---
 rtl/clk_pulse_scheduler.sv | 102 ++++++++++
 tb/tb_clk_pulse_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/clk_pulse_scheduler.sv
// clk_pulse_scheduler: sequences a programmable gated clock/pulse burst from a latched config.
module clk_pulse_scheduler #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half_period,
    input  logic               cfg_start_value,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               gen_out,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   edge_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0]   half, half_n, cnt, cnt_n, edge_n, cfg_half;
    logic [BURST_W-1:0] burst, burst_n, left, left_n;
    logic               sv, sv_n, gen_n, tick_n;
    assign cfg_half = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;
    // A finished burst is retired one cycle after its last toggle so that toggle stays visible.
    always_comb begin
        state_n = state;
        half_n  = half;
        sv_n    = sv;
        burst_n = burst;
        cnt_n   = cnt;
        left_n  = left;
        gen_n   = gen_out;
        tick_n  = 1'b0;
        edge_n  = edge_count;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    half_n  = cfg_half;
                    sv_n    = cfg_start_value;
                    burst_n = cfg_burst;
                end
                if (start && !stop) begin
                    state_n = RUN;
                    gen_n   = sv_n;
                    cnt_n   = half_n - CNT_W'(1);
                    left_n  = burst_n;
                    edge_n  = '0;
                end
            end
            RUN: begin
                if (stop || (burst != '0 && left == '0)) begin
                    state_n = DONE;
                    gen_n   = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    gen_n  = !gen_out;
                    tick_n = 1'b1;
                    edge_n = edge_count + CNT_W'(1);
                    cnt_n  = half - CNT_W'(1);
                    left_n = (burst != '0) ? left - BURST_W'(1) : left;
                end
            end
            default: begin
                state_n = IDLE;
                gen_n   = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            half       <= CNT_W'(1);
            sv         <= 1'b0;
            burst      <= '0;
            cnt        <= '0;
            left       <= '0;
            gen_out    <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_ready  <= 1'b1;
            edge_count <= '0;
        end else begin
            state      <= state_n;
            half       <= half_n;
            sv         <= sv_n;
            burst      <= burst_n;
            cnt        <= cnt_n;
            left       <= left_n;
            gen_out    <= gen_n;
            tick       <= tick_n;
            busy       <= (state_n == RUN);
            done       <= (state_n == DONE);
            cfg_ready  <= (state_n == IDLE);
            edge_count <= edge_n;
        end
    end
endmodule

// File: tb/tb_clk_pulse_scheduler.sv
// tb_clk_pulse_scheduler: directed bench; per-cycle expectations queued from a closed-form waveform model.
module tb_clk_pulse_scheduler;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_valid = 1'b0, cfg_ready, cfg_start_value = 1'b0;
    logic [15:0] cfg_half_period = '0, edge_count;
    logic [7:0]  cfg_burst = '0;
    logic        start = 1'b0, stop = 1'b0, gen_out, tick, busy, done;
    int          vecs = 0, errs = 0, last_ec = 0;

    typedef struct packed {
        logic gen, tck, bsy, dn, rdy;
        logic [15:0] ec;
    } exp_t;
    exp_t q[$];

    clk_pulse_scheduler dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_half_period(cfg_half_period), .cfg_start_value(cfg_start_value),
        .cfg_burst(cfg_burst), .start(start), .stop(stop), .gen_out(gen_out),
        .tick(tick), .busy(busy), .done(done), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic g, logic t, logic b, logic d, logic r, int ec);
        exp_t e;
        e.gen = g; e.tck = t; e.bsy = b; e.dn = d; e.rdy = r; e.ec = 16'(ec);
        return e;
    endfunction

    task automatic step(string tag);
        exp_t e, a;
        @(posedge clk);
        #1;
        e = q.pop_front();
        a = mk(gen_out, tick, busy, done, cfg_ready, int'(edge_count));
        vecs++;
        assert (a === e) else begin
            errs++;
            $error("FAIL %s: got gen=%b tick=%b busy=%b done=%b ready=%b ec=%0d, expected gen=%b tick=%b busy=%b done=%b ready=%b ec=%0d",
                   tag, a.gen, a.tck, a.bsy, a.dn, a.rdy, a.ec, e.gen, e.tck, e.bsy, e.dn, e.rdy, e.ec);
        end
    endtask

    task automatic idle(string tag);
        q.push_back(mk(0, 0, 0, 0, 1, last_ec));
        step(tag);
    endtask

    task automatic cfg(int h, bit s, int b);
        cfg_half_period = 16'(h); cfg_start_value = s; cfg_burst = 8'(b); cfg_valid = 1'b1;
        idle("cfg");
        cfg_valid = 1'b0;
    endtask

    // k counts edges from the one that samples start; k==n is the DONE cycle.
    task automatic run(string tag, int h, bit s, int b, int stop_at, bit poke, bit cfg_now, int rst_at);
        int he = (h == 0) ? 1 : h;
        int n  = (stop_at > 0) ? stop_at : b * he + 1;
        int lastk = (rst_at > 0) ? rst_at : n + 1;
        for (int k = 0; k <= lastk; k++)
            if (rst_at > 0 && k == rst_at) q.push_back(mk(0, 0, 0, 0, 1, 0));
            else if (k < n) q.push_back(mk(s ^ ((k / he) % 2 == 1), k > 0 && k % he == 0, 1, 0, 0, k / he));
            else q.push_back(mk(0, 0, 0, k == n, k > n, (n - 1) / he));
        if (cfg_now) begin
            cfg_half_period = 16'(h); cfg_start_value = s; cfg_burst = 8'(b); cfg_valid = 1'b1;
        end
        start = 1'b1;
        for (int k = 0; k <= lastk; k++) begin
            stop = (stop_at > 0 && k == stop_at);
            rst  = (rst_at > 0 && k == rst_at);
            if (poke && k == 2) begin
                cfg_half_period = 16'd7; cfg_start_value = ~s; cfg_burst = 8'd1;
                cfg_valid = 1'b1; start = 1'b1;
            end
            step(tag);
            start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; rst = 1'b0;
        end
        last_ec = (rst_at > 0) ? 0 : (n - 1) / he;
    endtask

    initial begin
        q.push_back(mk(0, 0, 0, 0, 1, 0));
        step("reset0");
        q.push_back(mk(0, 0, 0, 0, 1, 0));
        step("reset1");
        rst = 1'b0;
        idle("post_reset");
        cfg(3, 0, 4);
        run("burst", 3, 0, 4, 0, 0, 0, 0);
        run("zero_half", 0, 1, 2, 0, 0, 1, 0);
        cfg(2, 0, 0);
        run("abort10", 2, 0, 0, 10, 0, 0, 0);
        idle("after_abort");
        run("abort9", 2, 0, 0, 9, 0, 0, 0);
        run("abort_on_toggle", 2, 0, 0, 6, 0, 0, 0);
        cfg(2, 1, 3);
        run("cfg_in_run", 2, 1, 3, 0, 1, 0, 0);
        run("old_cfg", 2, 1, 3, 0, 0, 0, 0);
        start = 1'b1; stop = 1'b1;
        idle("start_stop_idle");
        start = 1'b0; stop = 1'b0;
        idle("still_idle");
        cfg(3, 0, 4);
        run("rst_mid", 3, 0, 4, 0, 0, 0, 4);
        idle("after_rst");
        run("default_cfg", 1, 0, 0, 3, 0, 0, 0);
        cfg(3, 0, 4);
        run("burst_again", 3, 0, 4, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
